// File: rtl/weight_bram_scheduler.sv
// weight_bram_scheduler: round-robin burst arbiter that shares one read-only weight BRAM among N_REQ loaders
module weight_bram_scheduler #(
    parameter int N_REQ      = 4,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 14,
    parameter int RD_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [N_REQ-1:0]            grant,
    output logic [W-1:0]                rd_data,
    output logic                        rd_valid,
    output logic                        rd_last,
    output logic [N_REQ-1:0]            done,
    output logic                        busy,
    output logic                        bram_en,
    output logic                        bram_ren,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    input  logic [W-1:0]                bram_dout
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d, owner_q, owner_d, sel;
    logic                  found;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [N_REQ-1:0]      grant_q, grant_d, done_q, done_d;
    logic                  en_q, en_d, ren_q, ren_d, ilast_q, ilast_d;
    logic [RD_LATENCY-1:0] vl_q, vl_d, ll_q, ll_d;
    logic [W-1:0]          data_q, data_d;
    logic                  valid_q, valid_d, last_q, last_d;

    // first asserted request at or after the pointer; scanning downward lets the nearest one win
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr_q) + i) % N_REQ]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    // burst FSM plus the read-valid/last delay lines that track BRAM latency
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        en_d    = en_q;
        ren_d   = 1'b0;
        ilast_d = 1'b0;
        addr_d  = addr_q;
        vl_d    = (vl_q << 1) | RD_LATENCY'(ren_q);
        ll_d    = (ll_q << 1) | RD_LATENCY'(ilast_q);
        valid_d = vl_q[RD_LATENCY-1];
        last_d  = ll_q[RD_LATENCY-1];
        data_d  = bram_dout;
        case (state_q)
            IDLE: if (found) begin
                owner_d = sel;
                base_d  = req_base[sel*ADDR_WIDTH +: ADDR_WIDTH];
                len_d   = req_len[sel*LEN_WIDTH +: LEN_WIDTH];
                cnt_d   = '0;
                grant_d = N_REQ'(1) << sel;
                // zero-length bursts skip the BRAM and let DRAIN see an empty line at once
                state_d = (len_d == '0) ? DRAIN : ISSUE;
            end
            ISSUE: begin
                en_d    = 1'b1;
                ren_d   = 1'b1;
                addr_d  = base_q + ADDR_WIDTH'(cnt_q);
                ilast_d = (cnt_q == len_q - LEN_WIDTH'(1));
                cnt_d   = cnt_q + LEN_WIDTH'(1);
                state_d = ilast_d ? DRAIN : ISSUE;
            end
            DRAIN: if (!ren_q && vl_q == '0) begin
                state_d = FIN;
                done_d  = grant_q;
                grant_d = '0;
                en_d    = 1'b0;
                addr_d  = '0;
            end
            FIN: begin
                ptr_d   = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
                state_d = IDLE;
            end
        endcase
    end

    // all state and outputs registered; reset discards any in-flight beats
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            en_q    <= 1'b0;
            ren_q   <= 1'b0;
            ilast_q <= 1'b0;
            addr_q  <= '0;
            vl_q    <= '0;
            ll_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            en_q    <= en_d;
            ren_q   <= ren_d;
            ilast_q <= ilast_d;
            addr_q  <= addr_d;
            vl_q    <= vl_d;
            ll_q    <= ll_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign bram_en   = en_q;
    assign bram_ren  = ren_q;
    assign bram_addr = addr_q;
    assign rd_valid  = valid_q;
    assign rd_last   = last_q;
    assign rd_data   = data_q;
endmodule

// File: tb/tb_weight_bram_scheduler.sv
// tb_weight_bram_scheduler: scoreboard bench for the shared weight BRAM scheduler
module tb_weight_bram_scheduler;
    localparam int N = 4, W = 8, AW = 18, LW = 14;

    logic          clk = 1'b0, rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*AW-1:0] req_base = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]  grant, done;
    logic [W-1:0]  rd_data, bram_dout = '0, p1 = '0;
    logic          rd_valid, rd_last, busy, bram_en, bram_ren;
    logic [AW-1:0] bram_addr;

    int pass_cnt = 0, tot_cnt = 0, ren_cnt = 0, valid_cnt = 0;
    bit sb_off = 1'b0;
    logic [31:0] exp_addr[$], exp_beat[$], exp_done[$], exp_grant[$];
    logic [N-1:0] prev_grant = '0;

    weight_bram_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_len(req_len),
        .grant(grant), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .busy(busy), .bram_en(bram_en), .bram_ren(bram_ren),
        .bram_addr(bram_addr), .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    // BRAM model: contents = addr[7:0], two-cycle read latency
    always @(posedge clk) begin
        p1        <= (bram_en && bram_ren) ? bram_addr[7:0] : 8'hEE;
        bram_dout <= p1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents an address, beat, done or new grant
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (bram_ren) ren_cnt++;
        if (rd_valid) valid_cnt++;
        if (!sb_off && !rst) begin
            if (bram_ren) begin
                e = exp_addr.size() ? exp_addr.pop_front() : 32'hDEADBEEF;
                chk("bram_addr", 32'(bram_addr), e);
            end
            if (rd_valid) begin
                e = exp_beat.size() ? exp_beat.pop_front() : 32'hDEADBEEF;
                chk("rd_last_data", {23'b0, rd_last, rd_data}, e);
            end
            if (done != '0) begin
                e = exp_done.size() ? exp_done.pop_front() : 32'hDEADBEEF;
                chk("done", 32'(done), e);
            end
            if (grant != '0 && grant != prev_grant) begin
                e = exp_grant.size() ? exp_grant.pop_front() : 32'hDEADBEEF;
                chk("grant", 32'(grant), e);
            end
        end
        prev_grant = grant;
    end

    task automatic set_req(input int i, input int base, input int len);
        req_base[i*AW +: AW] = AW'(base);
        req_len[i*LW +: LW]  = LW'(len);
    endtask

    task automatic push_burst(input int own, input int base, input int len);
        exp_grant.push_back(32'(1) << own);
        for (int k = 0; k < len; k++) begin
            logic [AW-1:0] a;
            a = AW'(base + k);
            exp_addr.push_back(32'(a));
            exp_beat.push_back({23'b0, k == len - 1, a[7:0]});
        end
        exp_done.push_back(32'(1) << own);
    endtask

    task automatic wait_done(input logic [N-1:0] drop);
        bit got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = (done != '0);
        end
        chk("done_seen", 32'(got), 1);
        req = req & ~drop;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc, vc, n;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_bram_en", 32'(bram_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // single burst with latency probe
        set_req(0, 119808, 4);
        push_burst(0, 119808, 4);
        req = 4'b0001;
        @(negedge clk);
        chk("t1_grant_next_cycle", 32'(grant), 1);
        chk("t1_busy", 32'(busy), 1);
        repeat (3) @(negedge clk);
        chk("t1_valid_not_early", 32'(rd_valid), 0);
        @(negedge clk);
        chk("t1_first_beat_time", 32'(rd_valid), 1);
        wait_done(4'b0001);

        // round robin with all requests held
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1000 + 100 * i, 2);
        for (int i = 0; i < 5; i++) push_burst(i % N, 1000 + 100 * (i % N), 2);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) wait_done(4'b0000);
        wait_done(4'b1111);

        // address wrap
        set_req(0, 262142, 4);
        push_burst(0, 262142, 4);
        req = 4'b0001;
        wait_done(4'b0001);

        // zero length
        rc = ren_cnt;
        vc = valid_cnt;
        set_req(2, 500, 0);
        push_burst(2, 500, 0);
        req = 4'b0100;
        wait_done(4'b0100);
        chk("t4_busy_low", 32'(busy), 0);
        chk("t4_no_ren", 32'(ren_cnt - rc), 0);
        chk("t4_no_valid", 32'(valid_cnt - vc), 0);

        // reset in the middle of a long burst
        sb_off = 1'b1;
        set_req(1, 5000, 100);
        req = 4'b0010;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(negedge clk);
            if (bram_ren) n++;
        end
        chk("t5_issued", 32'(n), 10);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("t5_grant", 32'(grant), 0);
        chk("t5_valid", 32'(rd_valid), 0);
        chk("t5_bram_en", 32'(bram_en), 0);
        chk("t5_busy", 32'(busy), 0);
        rst = 1'b0;
        vc = valid_cnt;
        repeat (6) @(negedge clk);
        chk("t5_no_valid_after_rst", 32'(valid_cnt - vc), 0);
        sb_off = 1'b0;
        set_req(0, 77, 1);
        set_req(3, 900, 3);
        push_burst(0, 77, 1);
        req = 4'b1011;
        wait_done(4'b1111);

        // requester drops mid-burst, base/len changed after latch
        set_req(1, 3000, 8);
        push_burst(1, 3000, 8);
        req = 4'b0010;
        n = 0;
        for (int c = 0; c < 50 && n == 0; c++) begin
            @(negedge clk);
            if (rd_valid) n = 1;
        end
        chk("t6_first_beat_seen", 32'(n), 1);
        req = '0;
        set_req(1, 7, 2);
        wait_done(4'b0000);

        repeat (5) @(negedge clk);
        chk("queues_empty", 32'(exp_addr.size() + exp_beat.size() + exp_done.size() + exp_grant.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
